// File: rtl/e32_wb_pkg.sv
// Shared types for the e32 writeback stage: source identifiers and the request payload.
package e32_wb_pkg;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  localparam int REG_COUNT = 32;
  localparam int REQ_SEL_W = $clog2(REG_COUNT);

  typedef struct packed {
    logic [REQ_SEL_W-1:0] sel;
    logic [31:0]          data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a hold input; req[0]/gnt[0] is the ALU side,
// req[1]/gnt[1] the LSU side. last_grant remembers who was served most recently.
module rr_arbiter2
  import e32_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt,
  output wb_src_e    last_grant
);

  wb_src_e    last_grant_d;
  wb_src_e    last_grant_q;
  logic [1:0] gnt_s;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_s = 2'b00;
    if (hold) begin
      gnt_s = 2'b00;
    end else if (req == 2'b11) begin
      gnt_s = (last_grant_q == WB_SRC_LSU) ? 2'b01 : 2'b10;
    end else begin
      gnt_s = req;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_s[0]) begin
      last_grant_d = WB_SRC_ALU;
    end else if (gnt_s[1]) begin
      last_grant_d = WB_SRC_LSU;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= WB_SRC_LSU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign gnt        = gnt_s;
  assign last_grant = last_grant_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the single register-file write port.
// The registered write port doubles as the decode bypass source.
module wb_arbiter
  import e32_wb_pkg::*;
#(
  parameter  int width_reg = 32,
  parameter  int CNT_W     = 16,
  localparam int SEL_W     = $clog2(width_reg)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [SEL_W-1:0] alu_sel,
  input  logic [31:0]      alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [SEL_W-1:0] lsu_sel,
  input  logic [31:0]      lsu_data,
  input  logic             wb_stall,
  output logic             rf_write,
  output logic [SEL_W-1:0] rf_select_w,
  output logic [31:0]      rf_data_write,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [1:0]       gnt_s;
  wb_src_e          last_grant_unused_s;

  logic             write_d;
  logic             write_q;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] sel_q;
  logic [31:0]      data_d;
  logic [31:0]      data_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  rr_arbiter2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        ({lsu_valid, alu_valid}),
    .hold       (wb_stall),
    .gnt        (gnt_s),
    .last_grant (last_grant_unused_s)
  );

  assign alu_ready = gnt_s[0];
  assign lsu_ready = gnt_s[1];

  // Select/data hold their last value when nothing is granted.
  always_comb begin
    write_d = gnt_s[0] | gnt_s[1];
    sel_d   = sel_q;
    data_d  = data_q;
    if (gnt_s[0]) begin
      sel_d  = alu_sel;
      data_d = alu_data;
    end else if (gnt_s[1]) begin
      sel_d  = lsu_sel;
      data_d = lsu_data;
    end else begin
      sel_d  = sel_q;
      data_d = data_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (alu_valid && lsu_valid && !wb_stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      sel_q   <= {SEL_W{1'b0}};
      data_q  <= 32'h0000_0000;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      write_q <= write_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_write      = write_q;
  assign rf_select_w   = sel_q;
  assign rf_data_write = data_q;
  assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a per-cycle behavioural model and a shadow register file.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid, lsu_valid, wb_stall;
  logic [4:0]  alu_sel, lsu_sel;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, rf_write;
  logic [4:0]  rf_select_w;
  logic [31:0] rf_data_write;
  logic [15:0] conflict_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  wb_arbiter #(.width_reg(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_sel(alu_sel), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_sel(lsu_sel), .lsu_data(lsu_data),
    .wb_stall(wb_stall),
    .rf_write(rf_write), .rf_select_w(rf_select_w), .rf_data_write(rf_data_write),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Winner by the rules: none when stalled, the lone requester, or on a tie whoever was not served last.
  // Returns -1 none, 0 ALU, 1 LSU.
  function automatic int pick(input logic av, input logic lv, input logic st, input int last);
    if (st) return -1;
    if (av && lv) return (last == 0) ? 1 : 0;
    if (av) return 0;
    if (lv) return 1;
    return -1;
  endfunction

  int          m_last;
  logic        m_write;
  logic [4:0]  m_sel;
  logic [31:0] m_data;
  int          m_cnt;
  int          m_w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last = 1; m_write = 1'b0; m_sel = 5'd0; m_data = 32'd0; m_cnt = 0;
    end else begin
      m_w = pick(alu_valid, lsu_valid, wb_stall, m_last);
      m_write = (m_w >= 0);
      if (m_w == 0) begin m_sel = alu_sel; m_data = alu_data; m_last = 0; end
      else if (m_w == 1) begin m_sel = lsu_sel; m_data = lsu_data; m_last = 1; end
      if (alu_valid && lsu_valid && !wb_stall && m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  end

  int c_w;
  always @(negedge clk) begin
    if (!rst) begin
      c_w = pick(alu_valid, lsu_valid, wb_stall, m_last);
      chk("model_alu_ready", {31'd0, alu_ready}, (c_w == 0) ? 32'd1 : 32'd0);
      chk("model_lsu_ready", {31'd0, lsu_ready}, (c_w == 1) ? 32'd1 : 32'd0);
      chk("model_rf_write", {31'd0, rf_write}, {31'd0, m_write});
      chk("model_rf_select_w", {27'd0, rf_select_w}, {27'd0, m_sel});
      chk("model_rf_data_write", rf_data_write, m_data);
      chk("model_conflict_cnt", {16'd0, conflict_cnt}, m_cnt);
    end
  end

  logic [31:0] shadow [32];
  always @(posedge clk) begin
    if (!rst && rf_write) shadow[rf_select_w] <= rf_data_write;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; lsu_valid = 1'b0; wb_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  int seq [4] = '{1, 2, 1, 2};

  initial begin
    idle();
    alu_sel = 5'd0; lsu_sel = 5'd0; alu_data = 32'd0; lsu_data = 32'd0;
    cyc();
    cyc();
    chk("reset_rf_write", {31'd0, rf_write}, 32'd0);
    chk("reset_rf_select_w", {27'd0, rf_select_w}, 32'd0);
    chk("reset_rf_data_write", rf_data_write, 32'd0);
    chk("reset_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
    rst = 1'b0;

    // Single ALU result: same-cycle ready, one-cycle latency to the write port.
    alu_valid = 1'b1; alu_sel = 5'd5; alu_data = 32'hDEAD_BEEF;
    #1;
    chk("single_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("single_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    cyc();
    chk("single_rf_write", {31'd0, rf_write}, 32'd1);
    chk("single_rf_select_w", {27'd0, rf_select_w}, 32'd5);
    chk("single_rf_data_write", rf_data_write, 32'hDEAD_BEEF);
    alu_valid = 1'b0;
    cyc();
    chk("idle_rf_write", {31'd0, rf_write}, 32'd0);
    chk("idle_select_hold", {27'd0, rf_select_w}, 32'd5);

    // Continuous dual valid alternates, starting with the ALU.
    do_reset();
    alu_valid = 1'b1; alu_sel = 5'd1; alu_data = 32'hA1;
    lsu_valid = 1'b1; lsu_sel = 5'd2; lsu_data = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_select_seq", {27'd0, rf_select_w}, seq[i]);
    end
    chk("rr_conflict_cnt", {16'd0, conflict_cnt}, 32'd4);

    // Stall with both valid: no grants, counter frozen; ALU first afterwards.
    wb_stall = 1'b1;
    #1;
    chk("stall_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("stall_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_rf_write", {31'd0, rf_write}, 32'd0);
    end
    chk("stall_conflict_cnt", {16'd0, conflict_cnt}, 32'd4);
    wb_stall = 1'b0;
    #1;
    chk("unstall_alu_first", {31'd0, alu_ready}, 32'd1);
    cyc();
    chk("unstall_rf_select_w", {27'd0, rf_select_w}, 32'd1);
    chk("unstall_conflict_cnt", {16'd0, conflict_cnt}, 32'd5);
    idle();

    // Both sources target r7: writes land in grant order, the later one sticks.
    do_reset();
    alu_valid = 1'b1; alu_sel = 5'd7; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_sel = 5'd7; lsu_data = 32'h22;
    cyc();
    chk("collide_first_data", rf_data_write, 32'h11);
    chk("collide_first_sel", {27'd0, rf_select_w}, 32'd7);
    alu_valid = 1'b0;
    cyc();
    chk("collide_second_data", rf_data_write, 32'h22);
    lsu_valid = 1'b0;
    cyc();
    cyc();
    chk("collide_final_r7", shadow[7], 32'h22);

    // Async reset right after a grant kills the in-flight write before any clock edge.
    alu_valid = 1'b1; alu_sel = 5'd9; alu_data = 32'h99;
    cyc();
    alu_valid = 1'b0;
    chk("pre_rst_rf_write", {31'd0, rf_write}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rf_write", {31'd0, rf_write}, 32'd0);
    chk("async_rst_select", {27'd0, rf_select_w}, 32'd0);
    chk("async_rst_cnt", {16'd0, conflict_cnt}, 32'd0);
    cyc();
    rst = 1'b0;
    alu_valid = 1'b1; alu_sel = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_sel = 5'd4; lsu_data = 32'h44;
    #1;
    chk("post_rst_alu_wins", {31'd0, alu_ready}, 32'd1);
    cyc();
    chk("post_rst_cnt", {16'd0, conflict_cnt}, 32'd1);
    idle();

    // Conflict counter saturation.
    do_reset();
    alu_valid = 1'b1; lsu_valid = 1'b1;
    repeat (65534) cyc();
    chk("sat_cnt_fffe", {16'd0, conflict_cnt}, 32'h0000_FFFE);
    cyc();
    chk("sat_cnt_ffff", {16'd0, conflict_cnt}, 32'h0000_FFFF);
    cyc();
    cyc();
    chk("sat_cnt_hold", {16'd0, conflict_cnt}, 32'h0000_FFFF);
    idle();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of register_file. It merges result streams from the ALU and the load/store unit onto the register file's single write port.
- Arbitration is round-robin between the two sources, with a valid/ready handshake on each input.
- Output is registered: one write per cycle to select_w / data_write / write.
- The registered write is also exported as a bypass bus, so decode can forward a value that is still being written.

Parameters:
- width_reg, 32, number of architectural registers; select width SEL_W = $clog2(width_reg).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-high.
- alu_valid  input  1  ALU result available.
- alu_ready  output  1  ALU result accepted this cycle.
- alu_sel  input  SEL_W  destination register of ALU result.
- alu_data  input  32  ALU result value.
- lsu_valid  input  1  load result available.
- lsu_ready  output  1  load result accepted this cycle.
- lsu_sel  input  SEL_W  destination register of load result.
- lsu_data  input  32  load result value.
- wb_stall  input  1  pipeline hold; no new grant while high.
- rf_write  output  1  drives register_file write.
- rf_select_w  output  SEL_W  drives register_file select_w.
- rf_data_write  output  32  drives register_file data_write.
- conflict_cnt  output  CNT_W  count of cycles where both sources were valid and unstalled; saturates.

Behaviour:
- Reset (async, rst=1):
  - Outputs: rf_write=0, rf_select_w=0, rf_data_write=0, conflict_cnt=0.
  - Internal: last_grant=LSU, so the ALU wins the first conflict.
  - rst asserted mid-transfer drops any in-flight registered write; no write reaches the register file that cycle.
- Grant (combinational, per cycle):
  - If wb_stall=1, grant none.
  - Otherwise, if only one source is valid, grant it.
  - If both are valid, grant the source not equal to last_grant.
  - alu_ready = grant_alu; lsu_ready = grant_lsu. A ready is never asserted without the matching valid, and at most one ready is high per cycle.
- Handshake:
  - A transfer occurs when valid && ready.
  - Sources hold sel/data stable while valid && !ready. The arbiter does not require this, since it samples on the transfer only.
  - A source may deassert valid without a transfer.
- Output register (at the edge after a grant):
  - rf_write <= (grant_alu | grant_lsu).
  - rf_select_w and rf_data_write <= the granted source's sel/data.
  - With no grant, rf_write <= 0 and select/data hold their previous values.
  - Latency is exactly 1 cycle from transfer to rf_write=1. The register file commits on the following edge.
- last_grant updates on every transfer to the granted source, including single-source transfers. It holds otherwise.
- conflict_cnt increments when alu_valid && lsu_valid && !wb_stall. It stops at 2^CNT_W-1 (no wrap).
- Same-register collision: if both sources target the same register, each is written in its own granted cycle, in grant order. The later write wins. No merging.
- Stall:
  - wb_stall=1 forces rf_write=0 on the next cycle.
  - A write already registered before the stall still presents for its one cycle.
- Bypass: consumers use rf_write/rf_select_w/rf_data_write directly as the forward source. Nothing is added combinationally.
- Throughput: 1 write/cycle. Under continuous dual valid, grants alternate ALU, LSU, ALU, ...

Decomposition:
- Package e32_wb_pkg holds:
  - typedef enum logic {WB_SRC_ALU, WB_SRC_LSU} wb_src_e;
  - localparam REG_COUNT = 32;
  - typedef struct packed {sel, data} wb_req_t.
- Sub-module rr_arbiter2: 2-requester round-robin with a hold input. Inputs req[1:0] and hold; outputs gnt[1:0] and the last_grant flop. It is reused for the later multi-port writeback.

Test Plan:
- Reset release, then alu_valid=1, sel=5, data=0xDEADBEEF -> alu_ready=1 the same cycle; next cycle rf_write=1, rf_select_w=5, rf_data_write=0xDEADBEEF.
- Both valid for 4 cycles after reset (ALU sel=1, LSU sel=2) -> grants ALU, LSU, ALU, LSU; conflict_cnt=4; rf_select_w sequence 1,2,1,2.
- Both valid with wb_stall=1 for 3 cycles -> both readies stay 0, rf_write=0, conflict_cnt unchanged. After stall release, ALU is granted first.
- Both target r7 (ALU data=0x11, LSU data=0x22) -> two writes in grant order, final register value 0x22.
- Assert rst asynchronously one cycle after a grant -> rf_write goes 0 immediately (before the clock edge); after release, last_grant=LSU and conflict_cnt=0.
- Force conflict_cnt to 0xFFFE and hold both valid 3 cycles -> counter reads 0xFFFF and stays there.
